// File: rtl/servo_pwm_multi_pkg.sv
// Shared helpers for the servo PWM generator: clock-to-microsecond divider,
// channel index width and pulse-width clamping.
package servo_pkg;

  typedef struct packed {
    logic [31:0] us;
    logic        clamped;
  } clamp_res_t;

  function automatic int us_div(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic clamp_res_t clamp_us(input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
    clamp_res_t r;
    r.clamped = 1'b1;
    if (v < lo)      r.us = lo;
    else if (v > hi) r.us = hi;
    else begin
      r.us      = v;
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_multi_channel.sv
// One servo output: clamped target register, frame-synchronous active register
// (optionally slew-limited when SERVO_SLEW_EN is defined) and the pulse compare.
module servo_channel
  import servo_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int MIN_US       = 500,
  parameter int MAX_US       = 2500,
`ifdef SERVO_SLEW_EN
  parameter int SLEW_STEP_US = 100,
`endif
  parameter int CENTER_US    = 1500
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             i_wr_en,
  input  logic [POS_W-1:0] i_wr_us,
  input  logic             i_frame_start,
  input  logic [POS_W-1:0] i_frame_cnt,
  output logic             o_clamp_hit,
  output logic             o_pwm
);

  clamp_res_t       w_clamp;
  logic [POS_W-1:0] r_target;
  logic [POS_W-1:0] r_active;
  logic [POS_W-1:0] w_frame_load;
  logic [POS_W-1:0] w_active_next;

  assign w_clamp     = clamp_us(32'(i_wr_us), MIN_US, MAX_US);
  assign o_clamp_hit = i_wr_en & w_clamp.clamped;

`ifdef SERVO_SLEW_EN
  always_comb begin
    w_frame_load = r_target;
    if (r_target > r_active) begin
      if (r_target - r_active > POS_W'(SLEW_STEP_US))
        w_frame_load = r_active + POS_W'(SLEW_STEP_US);
    end else if (r_active - r_target > POS_W'(SLEW_STEP_US)) begin
      w_frame_load = r_active - POS_W'(SLEW_STEP_US);
    end
  end
`else
  assign w_frame_load = r_target;
`endif

  // The compare uses the value being loaded so the first pulse cycle of a
  // frame already reflects the new width.
  assign w_active_next = i_frame_start ? w_frame_load : r_active;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_target <= POS_W'(CENTER_US);
      r_active <= POS_W'(CENTER_US);
      o_pwm    <= 1'b0;
    end else begin
      if (i_wr_en) r_target <= POS_W'(w_clamp.us);
      r_active <= w_active_next;
      o_pwm    <= (i_frame_cnt < w_active_next);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM top: microsecond prescaler, frame counter, write
// decode and CHANNELS servo_channel instances. Optional slew: SERVO_SLEW_EN.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int CLK_HZ       = 24_000_000,
  parameter int CHANNELS     = 4,
  parameter int POS_W        = 16,
  parameter int PERIOD_US    = 20000,
  parameter int MIN_US       = 500,
  parameter int MAX_US       = 2500,
  parameter int CENTER_US    = 1500,
  parameter int SLEW_STEP_US = 100
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          wr_valid,
  input  logic [ch_width(CHANNELS)-1:0] wr_ch,
  input  logic [POS_W-1:0]              wr_us,
  output logic                          wr_clamp,
  output logic                          frame_start,
  output logic [CHANNELS-1:0]           pwm
);

  localparam int US_DIV  = us_div(CLK_HZ);
  localparam int CH_W    = ch_width(CHANNELS);
  localparam int PRESC_W = $clog2(US_DIV);

  if (CLK_HZ % 1_000_000 != 0 || US_DIV < 2 || CHANNELS < 1 || CHANNELS > 16 ||
      MIN_US > MAX_US || MAX_US >= PERIOD_US || SLEW_STEP_US < 1) begin : g_bad_cfg
    $error("servo_pwm_multi: invalid parameter set");
  end

  logic [PRESC_W-1:0]  r_presc;
  logic [POS_W-1:0]    r_frame_cnt;
  logic                w_us_tick;
  logic                w_frame_wrap;
  logic [CHANNELS-1:0] w_wr_en;
  logic [CHANNELS-1:0] w_clamp_hit;

  assign w_us_tick    = (r_presc == PRESC_W'(US_DIV - 1));
  assign w_frame_wrap = w_us_tick && (r_frame_cnt == POS_W'(PERIOD_US - 1));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_presc     <= '0;
      r_frame_cnt <= POS_W'(PERIOD_US - 1);
      frame_start <= 1'b0;
      wr_clamp    <= 1'b0;
    end else begin
      r_presc <= w_us_tick ? '0 : r_presc + PRESC_W'(1);
      if (w_us_tick)
        r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + POS_W'(1);
      frame_start <= w_frame_wrap;
      wr_clamp    <= |w_clamp_hit;
    end
  end

  // Out-of-range channel indices match no decode line and are dropped.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_wr_en[gi] = wr_valid && (wr_ch == CH_W'(gi));

    servo_channel #(
      .POS_W        (POS_W),
      .MIN_US       (MIN_US),
      .MAX_US       (MAX_US),
`ifdef SERVO_SLEW_EN
      .SLEW_STEP_US (SLEW_STEP_US),
`endif
      .CENTER_US    (CENTER_US)
    ) u_ch (
      .clk           (clk),
      .resetb        (resetb),
      .i_wr_en       (w_wr_en[gi]),
      .i_wr_us       (wr_us),
      .i_frame_start (frame_start),
      .i_frame_cnt   (r_frame_cnt),
      .o_clamp_hit   (w_clamp_hit[gi]),
      .o_pwm         (pwm[gi])
    );
  end

endmodule
